lif_calcium_pipe: RTL and testbench

Parametrised, registered calcium-concentration update unit for the SDSP learning path. It replaces the purely combinational calcium logic with a one-stage valid/ready pipeline between the neuron-state SRAM read and write-back. It generalises the widths, adds a programmable spike increment and a robust leak-counter wrap, and optionally keeps SDSP UP/DOWN event statistics. It sits after the LIF membrane update. It consumes that update's next membrane state and spike flag, and returns next calcium state, next leak counter and the SDSP UP/DOWN condition bits.

---
 rtl/lif_calcium_pipe.sv | 126 ++++++++++++
 tb/tb_lif_calcium_pipe.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lif_calcium_pipe.sv
// Registered calcium / leak-counter update for the SDSP learning path, one-stage valid/ready pipe.
// Optional SDSP UP/DOWN event statistics are enabled by defining CA_EVENT_CNT_EN.
module lif_calcium_pipe #(
    parameter int CA_W   = 3,
    parameter int MEM_W  = 8,
    parameter int LEAK_W = 5
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              param_ca_en,
    input  logic [MEM_W-1:0]  param_thetamem,
    input  logic [CA_W-1:0]   param_ca_theta1,
    input  logic [CA_W-1:0]   param_ca_theta2,
    input  logic [CA_W-1:0]   param_ca_theta3,
    input  logic [CA_W-1:0]   param_ca_inc,
    input  logic [LEAK_W-1:0] param_caleak,
    input  logic [CA_W-1:0]   state_calcium,
    input  logic [LEAK_W-1:0] state_caleak_cnt,
    input  logic [MEM_W-1:0]  state_core_next,
    input  logic              spike_out,
    input  logic              event_tref,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CA_W-1:0]   state_calcium_next,
    output logic [LEAK_W-1:0] state_caleak_cnt_next,
    output logic              v_up_next,
    output logic              v_down_next
`ifdef CA_EVENT_CNT_EN
    ,
    input  logic              cnt_clr,
    output logic [15:0]       up_cnt,
    output logic [15:0]       down_cnt
`endif
);

    logic              out_valid_q;
    logic [CA_W-1:0]   ca_q, ca_d;
    logic [LEAK_W-1:0] cnt_q, cnt_d;
    logic              up_q, up_d;
    logic              down_q, down_d;
    logic              leak_step;
    logic              leak;
    logic [CA_W+1:0]   ca_sum;
    logic              accept;

    assign in_ready = ~out_valid_q | out_ready;
    assign accept   = in_valid & in_ready;

    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        leak      = 1'b0;
        cnt_d     = state_caleak_cnt;
        leak_step = param_ca_en && (param_caleak != '0) && event_tref;
        // >= rather than == so a counter stranded above a shortened period still wraps.
        if (leak_step) begin
            if (state_caleak_cnt >= param_caleak - LEAK_W'(1)) begin
                cnt_d = '0;
                leak  = 1'b1;
            end else begin
                cnt_d = state_caleak_cnt + LEAK_W'(1);
            end
        end

        // Two guard bits: bit CA_W+1 flags underflow, bit CA_W flags overflow.
        ca_sum = {2'b00, state_calcium}
               + (spike_out ? {2'b00, param_ca_inc} : '0)
               - {{(CA_W+1){1'b0}}, leak};
        if (!param_ca_en)        ca_d = state_calcium;
        else if (ca_sum[CA_W+1]) ca_d = '0;
        else if (ca_sum[CA_W])   ca_d = '1;
        else                     ca_d = ca_sum[CA_W-1:0];

        up_d   = param_ca_en && (state_core_next >= param_thetamem)
              && (ca_d >= param_ca_theta1) && (ca_d < param_ca_theta3);
        down_d = param_ca_en && (state_core_next < param_thetamem)
              && (ca_d >= param_ca_theta1) && (ca_d < param_ca_theta2);
    end

    // NOTE: sequential state uses non-blocking assignments only; reset is synchronous.
    always_ff @(posedge CLK) begin
        if (RST) begin
            out_valid_q <= 1'b0;
            ca_q        <= '0;
            cnt_q       <= '0;
            up_q        <= 1'b0;
            down_q      <= 1'b0;
        end else if (accept) begin
            out_valid_q <= 1'b1;
            ca_q        <= ca_d;
            cnt_q       <= cnt_d;
            up_q        <= up_d;
            down_q      <= down_d;
        end else if (out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign out_valid             = out_valid_q;
    assign state_calcium_next    = ca_q;
    assign state_caleak_cnt_next = cnt_q;
    assign v_up_next             = up_q;
    assign v_down_next           = down_q;

`ifdef CA_EVENT_CNT_EN
    logic [15:0] up_cnt_q, down_cnt_q;
    logic        handshake;

    assign handshake = out_valid_q & out_ready;

    always_ff @(posedge CLK) begin
        if (RST || cnt_clr) begin
            up_cnt_q   <= '0;
            down_cnt_q <= '0;
        end else if (handshake) begin
            if (up_q && (up_cnt_q != 16'hFFFF))     up_cnt_q   <= up_cnt_q + 16'd1;
            if (down_q && (down_cnt_q != 16'hFFFF)) down_cnt_q <= down_cnt_q + 16'd1;
        end
    end

    assign up_cnt   = up_cnt_q;
    assign down_cnt = down_cnt_q;
`endif

endmodule

// File: tb/tb_lif_calcium_pipe.sv
// Scoreboard bench for lif_calcium_pipe: expectations queued at accept, compared at output handshake.
module tb_lif_calcium_pipe;

    localparam int CA_W   = 3;
    localparam int MEM_W  = 8;
    localparam int LEAK_W = 5;

    typedef struct {
        logic [CA_W-1:0]   ca;
        logic [LEAK_W-1:0] cnt;
        logic              up;
        logic              down;
    } exp_t;

    logic              CLK = 1'b0;
    logic              RST = 1'b1;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic              param_ca_en = 1'b0;
    logic [MEM_W-1:0]  param_thetamem = '0;
    logic [CA_W-1:0]   param_ca_theta1 = '0;
    logic [CA_W-1:0]   param_ca_theta2 = '0;
    logic [CA_W-1:0]   param_ca_theta3 = '0;
    logic [CA_W-1:0]   param_ca_inc = '0;
    logic [LEAK_W-1:0] param_caleak = '0;
    logic [CA_W-1:0]   state_calcium = '0;
    logic [LEAK_W-1:0] state_caleak_cnt = '0;
    logic [MEM_W-1:0]  state_core_next = '0;
    logic              spike_out = 1'b0;
    logic              event_tref = 1'b0;
    logic              out_valid;
    logic              out_ready = 1'b1;
    logic [CA_W-1:0]   state_calcium_next;
    logic [LEAK_W-1:0] state_caleak_cnt_next;
    logic              v_up_next;
    logic              v_down_next;
`ifdef CA_EVENT_CNT_EN
    logic              cnt_clr = 1'b0;
    logic [15:0]       up_cnt;
    logic [15:0]       down_cnt;
    int                up_m = 0;
    int                down_m = 0;
`endif

    int   checks = 0;
    int   failures = 0;
    exp_t sb[$];

    always #5 CLK = ~CLK;

    lif_calcium_pipe #(.CA_W(CA_W), .MEM_W(MEM_W), .LEAK_W(LEAK_W)) dut (
        .CLK                   (CLK),
        .RST                   (RST),
        .in_valid              (in_valid),
        .in_ready              (in_ready),
        .param_ca_en           (param_ca_en),
        .param_thetamem        (param_thetamem),
        .param_ca_theta1       (param_ca_theta1),
        .param_ca_theta2       (param_ca_theta2),
        .param_ca_theta3       (param_ca_theta3),
        .param_ca_inc          (param_ca_inc),
        .param_caleak          (param_caleak),
        .state_calcium         (state_calcium),
        .state_caleak_cnt      (state_caleak_cnt),
        .state_core_next       (state_core_next),
        .spike_out             (spike_out),
        .event_tref            (event_tref),
        .out_valid             (out_valid),
        .out_ready             (out_ready),
        .state_calcium_next    (state_calcium_next),
        .state_caleak_cnt_next (state_caleak_cnt_next),
        .v_up_next             (v_up_next),
        .v_down_next           (v_down_next)
`ifdef CA_EVENT_CNT_EN
        ,
        .cnt_clr               (cnt_clr),
        .up_cnt                (up_cnt),
        .down_cnt              (down_cnt)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference model of one update, evaluated from the inputs currently driven.
    function automatic exp_t model();
        exp_t e;
        int   c, k, mx;
        bit   lk;
        c  = int'(state_calcium);
        k  = int'(state_caleak_cnt);
        mx = (1 << CA_W) - 1;
        lk = 1'b0;
        e.up = 1'b0;
        e.down = 1'b0;
        if (param_ca_en) begin
            if (param_caleak != 0 && event_tref) begin
                if (k >= int'(param_caleak) - 1) begin
                    k  = 0;
                    lk = 1'b1;
                end else begin
                    k = k + 1;
                end
            end
            if (spike_out) c = c + int'(param_ca_inc);
            if (lk) c = c - 1;
            if (c < 0) c = 0;
            if (c > mx) c = mx;
            e.up   = (state_core_next >= param_thetamem) && (c >= int'(param_ca_theta1)) && (c < int'(param_ca_theta3));
            e.down = (state_core_next <  param_thetamem) && (c >= int'(param_ca_theta1)) && (c < int'(param_ca_theta2));
        end
        e.ca  = c[CA_W-1:0];
        e.cnt = k[LEAK_W-1:0];
        return e;
    endfunction

    // Called at a falling edge with inputs already driven; returns at the next falling edge.
    task automatic tick();
        bit   acc, drn;
        exp_t e;
        #1;
        acc = in_valid && in_ready;
        drn = out_valid && out_ready;
        if (drn) begin
            if (sb.size() == 0) begin
                check("sb_underflow", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                check("ca_next",  32'(state_calcium_next),    32'(e.ca));
                check("cnt_next", 32'(state_caleak_cnt_next), 32'(e.cnt));
                check("v_up",     32'(v_up_next),             32'(e.up));
                check("v_down",   32'(v_down_next),           32'(e.down));
`ifdef CA_EVENT_CNT_EN
                if (e.up && up_m != 16'hFFFF) up_m++;
                if (e.down && down_m != 16'hFFFF) down_m++;
`endif
            end
        end
`ifdef CA_EVENT_CNT_EN
        if (cnt_clr) begin
            up_m = 0;
            down_m = 0;
        end
`endif
        if (acc) sb.push_back(model());
        @(negedge CLK);
    endtask

    task automatic set_in(input logic en, input logic [CA_W-1:0] ca, input logic [CA_W-1:0] inc,
                          input logic [LEAK_W-1:0] caleak, input logic [LEAK_W-1:0] cnt,
                          input logic spike, input logic tref, input logic [MEM_W-1:0] core);
        in_valid         = 1'b1;
        param_ca_en      = en;
        state_calcium    = ca;
        param_ca_inc     = inc;
        param_caleak     = caleak;
        state_caleak_cnt = cnt;
        spike_out        = spike;
        event_tref       = tref;
        state_core_next  = core;
    endtask

    initial begin
        param_thetamem  = 8'd100;
        param_ca_theta1 = 3'd2;
        param_ca_theta2 = 3'd4;
        param_ca_theta3 = 3'd6;
        repeat (3) @(negedge CLK);
        RST = 1'b0;
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_ca",        32'(state_calcium_next), 32'd0);
        check("rst_cnt",       32'(state_caleak_cnt_next), 32'd0);
        check("rst_vup",       32'(v_up_next), 32'd0);
        check("rst_in_ready",  32'(in_ready), 32'd1);
`ifdef CA_EVENT_CNT_EN
        check("rst_up_cnt",    32'(up_cnt), 32'd0);
        check("rst_down_cnt",  32'(down_cnt), 32'd0);
`endif
        @(negedge CLK);

        // Directed cases, back to back with out_ready=1.
        set_in(1, 3'd3, 3'd2, 5'd0, 5'd0, 1, 0, 8'd0);      tick();
        check("latency_valid", 32'(out_valid), 32'd1);
        check("basic_ca",      32'(state_calcium_next), 32'd5);
        set_in(1, 3'd6, 3'd3, 5'd0, 5'd0, 1, 0, 8'd0);      tick();
        set_in(1, 3'd0, 3'd0, 5'd1, 5'd0, 0, 1, 8'd0);      tick();
        set_in(1, 3'd5, 3'd0, 5'd4, 5'd3, 0, 1, 8'd0);      tick();
        check("leak_wrap_cnt", 32'(state_caleak_cnt_next), 32'd0);
        set_in(1, 3'd5, 3'd0, 5'd4, 5'd9, 0, 1, 8'd0);      tick();
        check("oor_wrap_ca",   32'(state_calcium_next), 32'd4);
        set_in(1, 3'd5, 3'd0, 5'd4, 5'd1, 0, 1, 8'd0);      tick();
        set_in(1, 3'd4, 3'd1, 5'd1, 5'd0, 1, 1, 8'd0);      tick();
        set_in(1, 3'd7, 3'd4, 5'd1, 5'd0, 1, 1, 8'd0);      tick();
        set_in(1, 3'd0, 3'd0, 5'd1, 5'd0, 1, 1, 8'd0);      tick();
        set_in(0, 3'd6, 3'd3, 5'd2, 5'd1, 1, 1, 8'd200);    tick();
        set_in(1, 3'd5, 3'd0, 5'd0, 5'd7, 0, 0, 8'd120);    tick();
        check("sdsp_up",       32'(v_up_next), 32'd1);
        set_in(1, 3'd3, 3'd0, 5'd0, 5'd7, 0, 0, 8'd50);     tick();
        check("sdsp_down",     32'(v_down_next), 32'd1);
        set_in(1, 3'd6, 3'd0, 5'd0, 5'd0, 0, 0, 8'd100);    tick();

        // Random traffic with random backpressure and parameters.
        for (int i = 0; i < 400; i++) begin
            param_thetamem  = MEM_W'($urandom);
            param_ca_theta1 = CA_W'($urandom);
            param_ca_theta2 = CA_W'($urandom);
            param_ca_theta3 = CA_W'($urandom);
            set_in(($urandom % 5) != 0, CA_W'($urandom), CA_W'($urandom), LEAK_W'($urandom % 8),
                   LEAK_W'($urandom), 1'($urandom), 1'($urandom), MEM_W'($urandom));
            in_valid  = ($urandom % 4) != 0;
            out_ready = ($urandom % 3) != 0;
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        tick();
        check("rand_drained", 32'(sb.size()), 32'd0);
`ifdef CA_EVENT_CNT_EN
        check("rand_up_cnt",   32'(up_cnt), 32'(up_m));
        check("rand_down_cnt", 32'(down_cnt), 32'(down_m));
`endif

        // Backpressure: hold a result for three cycles, then drain and accept together.
        param_thetamem  = 8'd100;
        param_ca_theta1 = 3'd2;
        param_ca_theta2 = 3'd4;
        param_ca_theta3 = 3'd6;
        set_in(1, 3'd2, 3'd3, 5'd0, 5'd0, 1, 0, 8'd120);    tick();
        out_ready = 1'b0;
        set_in(1, 3'd1, 3'd1, 5'd0, 5'd0, 1, 0, 8'd10);
        for (int i = 0; i < 3; i++) begin
            #1;
            check("bp_in_ready", 32'(in_ready), 32'd0);
            check("bp_valid",    32'(out_valid), 32'd1);
            check("bp_ca_hold",  32'(state_calcium_next), 32'(sb[0].ca));
            check("bp_up_hold",  32'(v_up_next), 32'(sb[0].up));
            tick();
        end
        out_ready = 1'b1;
        #1;
        check("bp_release_ready", 32'(in_ready), 32'd1);
        tick();
        check("bp_refill_valid", 32'(out_valid), 32'd1);
        check("bp_refill_ca",    32'(state_calcium_next), 32'd2);
        check("bp_sb_depth",     32'(sb.size()), 32'd1);
        in_valid = 1'b0;
        tick();

`ifdef CA_EVENT_CNT_EN
        // Saturate up_cnt, then clear it.
        set_in(1, 3'd5, 3'd0, 5'd0, 5'd0, 0, 0, 8'd120);
        for (int i = 0; i < 70000; i++) tick();
        in_valid = 1'b0;
        tick();
        check("up_cnt_sat",   32'(up_cnt), 32'hFFFF);
        check("up_cnt_model", 32'(up_cnt), 32'(up_m));
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        check("up_cnt_clr",   32'(up_cnt), 32'd0);
        check("down_cnt_clr", 32'(down_cnt), 32'd0);
`endif

        // Reset during a stall discards the held result.
        set_in(1, 3'd4, 3'd2, 5'd0, 5'd0, 1, 0, 8'd0);      tick();
        out_ready = 1'b0;
        in_valid  = 1'b0;
        tick();
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        sb.delete();
`ifdef CA_EVENT_CNT_EN
        up_m = 0;
        down_m = 0;
`endif
        #1;
        check("rst_stall_valid", 32'(out_valid), 32'd0);
        check("rst_stall_ca",    32'(state_calcium_next), 32'd0);
        check("rst_stall_ready", 32'(in_ready), 32'd1);
        out_ready = 1'b1;
        @(negedge CLK);
        set_in(1, 3'd1, 3'd3, 5'd0, 5'd0, 1, 0, 8'd0);      tick();
        in_valid = 1'b0;
        tick();
        tick();
        check("final_empty", 32'(sb.size()), 32'd0);
        check("final_valid", 32'(out_valid), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
